// File: rtl/async_transmitter_if.sv
// Byte-write side of the UART transmitter: application pushes bytes, the
// transmitter reports line and queue status back.
interface async_transmitter_if #(
  parameter int FifoDepth = 4
);
  localparam int CntW = $clog2(FifoDepth) + 1;

  logic [7:0]      TxD_data;
  logic            TxD_wr;
  logic            TxD;
  logic            busy;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CntW-1:0] fifo_count;
  logic            overflow;

  modport master (
    output TxD_data, TxD_wr,
    input  TxD, busy, fifo_full, fifo_empty, fifo_count, overflow
  );

  modport slave (
    input  TxD_data, TxD_wr,
    output TxD, busy, fifo_full, fifo_empty, fifo_count, overflow
  );
endinterface

// File: rtl/async_transmitter.sv
// UART 8N1 transmitter with a small write FIFO and its own bit-period divider.
// TxD is registered from the current state, so it lags the FSM by one clock.
module async_transmitter #(
  parameter int ClkFrequency = 50000000,
  parameter int Baud         = 115200,
  parameter int FifoDepth    = 4
) (
  input logic               clk,
  input logic               rst,
  async_transmitter_if.slave tx
);
  localparam int Divisor = ClkFrequency / Baud;
  localparam int DivW    = (Divisor > 1) ? $clog2(Divisor) : 1;
  localparam int PtrW    = $clog2(FifoDepth);
  localparam int CntW    = PtrW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state;
  logic [DivW-1:0] div;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic            txd_q;

  logic [7:0]      mem [FifoDepth];
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic [CntW-1:0] count;
  logic            ovf_q;

  logic div_end;
  logic full;
  logic empty;
  logic wr_en;
  logic pop;

  // A write is refused whenever the queue is full, even if a pop frees a slot
  // in the same cycle.
  always_comb begin
    div_end = (div == DivW'(Divisor - 1));
    full    = (count == CntW'(FifoDepth));
    empty   = (count == '0);
    wr_en   = tx.TxD_wr && !full;
    pop     = !empty && ((state == IDLE) || ((state == STOP) && div_end));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      ovf_q <= tx.TxD_wr && full;
      if (wr_en) begin
        mem[wr_ptr] <= tx.TxD_data;
        wr_ptr      <= wr_ptr + PtrW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PtrW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      div     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      txd_q   <= 1'b1;
    end else begin
      case (state)
        START:   txd_q <= 1'b0;
        DATA:    txd_q <= shift[0];
        default: txd_q <= 1'b1;
      endcase

      case (state)
        IDLE: begin
          div <= '0;
          if (pop) begin
            shift <= mem[rd_ptr];
            state <= START;
          end
        end
        START: begin
          if (div_end) begin
            div     <= '0;
            bit_idx <= '0;
            state   <= DATA;
          end else begin
            div <= div + DivW'(1);
          end
        end
        DATA: begin
          if (div_end) begin
            div     <= '0;
            shift   <= {1'b0, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7)
              state <= STOP;
          end else begin
            div <= div + DivW'(1);
          end
        end
        STOP: begin
          if (div_end) begin
            div <= '0;
            // Chain straight into the next frame so queued bytes leave gap-free.
            if (pop) begin
              shift <= mem[rd_ptr];
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            div <= div + DivW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign tx.TxD        = txd_q;
  assign tx.busy       = (state != IDLE);
  assign tx.fifo_full  = full;
  assign tx.fifo_empty = empty;
  assign tx.fifo_count = count;
  assign tx.overflow   = ovf_q;
endmodule

// File: tb/tb_async_transmitter.sv
// Directed bench for async_transmitter at Divisor=10, FifoDepth=4.
// Sample index i counts edges after the first write; TxD frames start at i=2.
module tb_async_transmitter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  async_transmitter_if #(.FifoDepth(4)) bus ();

  async_transmitter #(
    .ClkFrequency(1000),
    .Baud        (100),
    .FifoDepth   (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tx (bus)
  );

  // Expected line level at position pos (0..99) within one frame of byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int pos);
    int n;
    n = pos / 10;
    if (n == 0) return 1'b0;
    if (n == 9) return 1'b1;
    return b[n-1];
  endfunction

  // Expected TxD after edge i for nfr contiguous frames beginning at i=2.
  function automatic logic line_at(input logic [7:0] fr [8], input int nfr, input int i);
    int k;
    int f;
    if (i < 2) return 1'b1;
    k = i - 2;
    f = k / 100;
    if (f >= nfr) return 1'b1;
    return frame_bit(fr[f], k % 100);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.TxD_wr   = 1'b0;
    bus.TxD_data = 8'h00;
    repeat (3) step();
    total++; if (bus.TxD !== 1'b1) begin bad++; $display("[TB] FAIL reset_txd got=%b want=1", bus.TxD); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", bus.busy); end
    total++; if (bus.fifo_empty !== 1'b1) begin bad++; $display("[TB] FAIL reset_empty got=%b want=1", bus.fifo_empty); end
    total++; if (bus.fifo_full !== 1'b0) begin bad++; $display("[TB] FAIL reset_full got=%b want=0", bus.fifo_full); end
    total++; if (bus.fifo_count !== 3'd0) begin bad++; $display("[TB] FAIL reset_count got=%0d want=0", bus.fifo_count); end
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("[TB] FAIL reset_overflow got=%b want=0", bus.overflow); end
    rst = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_single();
    logic [7:0] fr [8];
    fr = '{default: 8'h00};
    fr[0] = 8'hA5;
    for (int i = 0; i <= 102; i++) begin
      bus.TxD_wr   = (i == 0);
      bus.TxD_data = 8'hA5;
      step();
      if (i == 0) begin
        total++; if (bus.fifo_count !== 3'd1) begin bad++; $display("[TB] FAIL single_count got=%0d want=1", bus.fifo_count); end
      end
      if (i >= 1) begin
        total++; if (bus.TxD !== line_at(fr, 1, i)) begin bad++; $display("[TB] FAIL single_txd i=%0d got=%b want=%b", i, bus.TxD, line_at(fr, 1, i)); end
      end
      total++; if (bus.busy !== (i >= 1 && i <= 100)) begin bad++; $display("[TB] FAIL single_busy i=%0d got=%b want=%b", i, bus.busy, (i >= 1 && i <= 100)); end
    end
    bus.TxD_wr = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] fr [8];
    int peak;
    fr = '{default: 8'h00};
    fr[0] = 8'h00; fr[1] = 8'hFF; fr[2] = 8'h55;
    peak = 0;
    for (int i = 0; i <= 302; i++) begin
      bus.TxD_wr   = (i < 3);
      bus.TxD_data = (i < 3) ? fr[i] : 8'h00;
      step();
      if (int'(bus.fifo_count) > peak) peak = int'(bus.fifo_count);
      if (i >= 1) begin
        total++; if (bus.TxD !== line_at(fr, 3, i)) begin bad++; $display("[TB] FAIL b2b_txd i=%0d got=%b want=%b", i, bus.TxD, line_at(fr, 3, i)); end
      end
      total++; if (bus.busy !== (i >= 1 && i <= 300)) begin bad++; $display("[TB] FAIL b2b_busy i=%0d got=%b want=%b", i, bus.busy, (i >= 1 && i <= 300)); end
      if (i == 202) begin
        total++; if (bus.fifo_empty !== 1'b1) begin bad++; $display("[TB] FAIL b2b_empty_third got=%b want=1", bus.fifo_empty); end
      end
    end
    total++; if (peak !== 2) begin bad++; $display("[TB] FAIL b2b_peak got=%0d want=2", peak); end
    bus.TxD_wr = 1'b0;
  endtask

  task automatic test_overflow();
    logic [7:0] fr [8];
    logic [7:0] wdata;
    int pulses;
    fr = '{default: 8'h00};
    fr[0] = 8'h11; fr[1] = 8'h21; fr[2] = 8'h32; fr[3] = 8'h43; fr[4] = 8'h54;
    pulses = 0;
    for (int i = 0; i <= 620; i++) begin
      case (i)
        0:       wdata = 8'h11;
        20:      wdata = 8'h21;
        21:      wdata = 8'h32;
        22:      wdata = 8'h43;
        23:      wdata = 8'h54;
        24:      wdata = 8'h65;
        default: wdata = 8'h00;
      endcase
      bus.TxD_wr   = (i == 0) || (i >= 20 && i <= 24);
      bus.TxD_data = wdata;
      step();
      if (bus.overflow === 1'b1) pulses++;
      if (i == 23) begin
        total++; if (bus.fifo_full !== 1'b1) begin bad++; $display("[TB] FAIL ovf_full got=%b want=1", bus.fifo_full); end
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("[TB] FAIL ovf_early got=%b want=0", bus.overflow); end
      end
      if (i == 24) begin
        total++; if (bus.overflow !== 1'b1) begin bad++; $display("[TB] FAIL ovf_pulse got=%b want=1", bus.overflow); end
        total++; if (bus.fifo_count !== 3'd4) begin bad++; $display("[TB] FAIL ovf_count got=%0d want=4", bus.fifo_count); end
      end
      if (i == 25) begin
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("[TB] FAIL ovf_pulse_end got=%b want=0", bus.overflow); end
      end
      if (i >= 1) begin
        total++; if (bus.TxD !== line_at(fr, 5, i)) begin bad++; $display("[TB] FAIL ovf_txd i=%0d got=%b want=%b", i, bus.TxD, line_at(fr, 5, i)); end
      end
      total++; if (bus.busy !== (i >= 1 && i <= 500)) begin bad++; $display("[TB] FAIL ovf_busy i=%0d got=%b want=%b", i, bus.busy, (i >= 1 && i <= 500)); end
    end
    total++; if (pulses !== 1) begin bad++; $display("[TB] FAIL ovf_pulse_count got=%0d want=1", pulses); end
    bus.TxD_wr = 1'b0;
  endtask

  task automatic test_simultaneous();
    logic [7:0] fr [8];
    logic [7:0] wdata;
    fr = '{default: 8'h00};
    fr[0] = 8'h11; fr[1] = 8'hA1; fr[2] = 8'hA2;
    fr[3] = 8'hA3; fr[4] = 8'hA4; fr[5] = 8'h77;
    for (int i = 0; i <= 660; i++) begin
      case (i)
        0:       wdata = 8'h11;
        10:      wdata = 8'hA1;
        11:      wdata = 8'hA2;
        12:      wdata = 8'hA3;
        13:      wdata = 8'hA4;
        101:     wdata = 8'h99;
        201:     wdata = 8'h77;
        default: wdata = 8'h00;
      endcase
      bus.TxD_wr   = (i == 0) || (i >= 10 && i <= 13) || (i == 101) || (i == 201);
      bus.TxD_data = wdata;
      step();
      if (i == 13) begin
        total++; if (bus.fifo_count !== 3'd4) begin bad++; $display("[TB] FAIL simul_fill got=%0d want=4", bus.fifo_count); end
      end
      if (i == 101) begin
        total++; if (bus.overflow !== 1'b1) begin bad++; $display("[TB] FAIL simul_full_ovf got=%b want=1", bus.overflow); end
        total++; if (bus.fifo_count !== 3'd3) begin bad++; $display("[TB] FAIL simul_full_count got=%0d want=3", bus.fifo_count); end
      end
      if (i == 201) begin
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("[TB] FAIL simul_three_ovf got=%b want=0", bus.overflow); end
        total++; if (bus.fifo_count !== 3'd3) begin bad++; $display("[TB] FAIL simul_three_count got=%0d want=3", bus.fifo_count); end
      end
      if (i >= 1) begin
        total++; if (bus.TxD !== line_at(fr, 6, i)) begin bad++; $display("[TB] FAIL simul_txd i=%0d got=%b want=%b", i, bus.TxD, line_at(fr, 6, i)); end
      end
      total++; if (bus.busy !== (i >= 1 && i <= 600)) begin bad++; $display("[TB] FAIL simul_busy i=%0d got=%b want=%b", i, bus.busy, (i >= 1 && i <= 600)); end
    end
    bus.TxD_wr = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] fr [8];
    int active;
    fr = '{default: 8'h00};
    fr[0] = 8'h3C;
    for (int i = 0; i <= 44; i++) begin
      bus.TxD_wr   = (i == 0) || (i == 5) || (i == 6);
      bus.TxD_data = (i == 0) ? 8'h3C : ((i == 5) ? 8'h5A : 8'h6B);
      step();
      if (i >= 1) begin
        total++; if (bus.TxD !== line_at(fr, 1, i)) begin bad++; $display("[TB] FAIL rstmid_txd i=%0d got=%b want=%b", i, bus.TxD, line_at(fr, 1, i)); end
      end
    end
    bus.TxD_wr = 1'b0;
    total++; if (bus.fifo_count !== 3'd2) begin bad++; $display("[TB] FAIL rstmid_queued got=%0d want=2", bus.fifo_count); end
    rst = 1'b1;
    step();
    total++; if (bus.TxD !== 1'b1) begin bad++; $display("[TB] FAIL rstmid_txd_abort got=%b want=1", bus.TxD); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_busy got=%b want=0", bus.busy); end
    total++; if (bus.fifo_count !== 3'd0) begin bad++; $display("[TB] FAIL rstmid_count got=%0d want=0", bus.fifo_count); end
    total++; if (bus.fifo_empty !== 1'b1) begin bad++; $display("[TB] FAIL rstmid_empty got=%b want=1", bus.fifo_empty); end
    step();
    rst = 1'b0;
    active = 0;
    for (int i = 0; i < 250; i++) begin
      step();
      if (bus.busy !== 1'b0 || bus.TxD !== 1'b1) active++;
    end
    total++; if (active !== 0) begin bad++; $display("[TB] FAIL rstmid_after got=%0d active cycles want=0", active); end
    total++; if (bus.fifo_count !== 3'd0) begin bad++; $display("[TB] FAIL rstmid_after_count got=%0d want=0", bus.fifo_count); end
  endtask

  initial begin
    bus.TxD_wr   = 1'b0;
    bus.TxD_data = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_simultaneous();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/async_transmitter.md
Name: async_transmitter

Overview:
- UART 8N1 transmitter; the transmit-direction counterpart of the design's UART receiver.
- Accepts bytes from on-chip logic through a small write FIFO and serialises them onto TxD: start bit, 8 data bits LSB first, one stop bit.
- Contains its own integer-divider bit-period counter, so no external baud tick is required.
- Sits between the application data path and the board TX pin.

Parameters:
- ClkFrequency, 50000000, system clock in Hz.
- Baud, 115200, line bit rate.
- Divisor is derived as ClkFrequency/Baud, truncated. Default is 434 clk cycles per bit. Must be >= 2.
- FifoDepth, 4, byte FIFO depth. Power of 2, >= 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-high.
- TxD_data  input  8  byte to queue.
- TxD_wr  input  1  write strobe. Byte accepted on any clk edge where TxD_wr=1 and fifo_full=0.
- TxD  output  1  serial line. Idle level is 1.
- busy  output  1  1 while a frame is on the line (state not IDLE).
- fifo_full  output  1  count == FifoDepth.
- fifo_empty  output  1  count == 0.
- fifo_count  output  $clog2(FifoDepth)+1  bytes queued, not including the byte currently shifting.
- overflow  output  1  one-cycle pulse on a write attempted while fifo_full=1.

Behaviour:
- Reset (rst=1 at an edge):
  - TxD=1, busy=0, fifo_count=0, fifo_empty=1, fifo_full=0, overflow=0.
  - FSM goes to IDLE. FIFO pointers, bit counter and divider counter all go to 0.
  - Reset mid-frame aborts the frame immediately (TxD=1 next cycle) and discards all FIFO contents.
- FIFO:
  - Circular buffer with read/write pointers that wrap modulo FifoDepth.
  - full/empty are combinational from the registered count.
  - Write and pop in the same cycle: count unchanged; both take effect.
  - Write while full: rejected even if a pop occurs in the same cycle. Data is dropped, overflow pulses, count unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: TxD=1. If fifo_empty=0, pop the head into the shift register, clear the divider, go to START.
  - A byte written into an empty FIFO in IDLE at edge N is popped at edge N+1. TxD falls after edge N+2.
  - START: TxD=0 for Divisor cycles, then go to DATA with bit index 0.
  - DATA: TxD=shift[0] for Divisor cycles per bit; shift right after each bit. After bit 7 completes, go to STOP.
  - STOP: TxD=1 for Divisor cycles. At the end of STOP:
    - if FIFO is non-empty, pop and go directly to START (no idle gap; back-to-back frames are exactly 10*Divisor cycles apart);
    - otherwise go to IDLE.
- Divider:
  - Counts 0..Divisor-1 in non-IDLE states. The bit boundary is at Divisor-1, where the divider wraps to 0.
  - Held at 0 in IDLE.
- TxD is registered (glitch-free). busy=1 in START, DATA and STOP.
- Frame length from the first start-bit cycle to the last stop-bit cycle is exactly 10*Divisor cycles.

Test Plan:
- Bench parameters: ClkFrequency=1000, Baud=100 (Divisor=10), FifoDepth=4.
- Reset check: hold rst 3 cycles -> TxD=1, busy=0, fifo_empty=1, fifo_count=0, overflow=0.
- Single byte: write 0xA5 at edge N -> TxD=0 for cycles N+2..N+11; then bits 1,0,1,0,0,1,0,1, each 10 cycles; then stop=1 for 10 cycles; busy falls after 100 cycles.
- Back-to-back: write 0x00, 0xFF, 0x55 on consecutive cycles -> three frames with no idle gap between them, frame starts exactly 100 cycles apart, fifo_count peaks at 2, fifo_empty=1 by the start of the third frame.
- Overflow: while 0x11 is shifting, write 5 bytes on consecutive cycles -> first 4 accepted, fifo_full=1, 5th write gives one overflow pulse, and only 4 further frames appear on TxD.
- Simultaneous write and pop: in a full FIFO, write on the STOP-end pop cycle -> write rejected with overflow=1. Repeat with count=3 -> accepted, count stays 3.
- Reset mid-frame: assert rst during DATA bit 3 with 2 bytes queued -> TxD=1 the next cycle, busy=0, fifo_count=0, and no further frames after rst is released.
